// File: rtl/fifo_pkg.sv
// Shared types and helpers for the UART FIFO pointer/flag controller.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 2;

    // Encoding matches the {push_ok, pop_ok} selector used by the controller.
    typedef enum logic [1:0] {
        NOP      = 2'b00,
        POP      = 2'b01,
        PUSH     = 2'b10,
        PUSH_POP = 2'b11
    } fifo_op_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_WIDTH-bit FIFO pointer with increment enable and a
// combinational successor output used by the full/empty look-ahead.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_ptr,
    output logic [WIDTH-1:0] o_succ
);

    logic [WIDTH-1:0] r_ptr;
    logic [WIDTH-1:0] w_succ;

    // Power-of-two depth: the natural binary wrap is the modulo.
    assign w_succ = r_ptr + WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= w_succ;
        end
    end

    assign o_ptr  = r_ptr;
    assign o_succ = w_succ;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the UART TX/RX FIFOs (first-word-fall-through).
// Optional feature macro FIFO_CTRL_THRESH_EN: registered almost_full/almost_empty thresholds.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    if (clog2(DEPTH + 1) != ADDR_WIDTH + 1 || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_param_check
        $error("fifo_ctrl: inconsistent ADDR_WIDTH / threshold parameters");
    end

    logic                  w_push_ok;
    logic                  w_pop_ok;
    fifo_op_t              w_op;
    logic [ADDR_WIDTH-1:0] w_wptr;
    logic [ADDR_WIDTH-1:0] w_rptr;
    logic [ADDR_WIDTH-1:0] w_wptr_succ;
    logic [ADDR_WIDTH-1:0] w_rptr_succ;

    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic                  w_ovf_set;
    logic                  w_unf_set;

    // A write into a full FIFO is still legal when the head leaves on the same edge.
    assign w_push_ok = wr & (~r_full | rd);
    assign w_pop_ok  = rd & ~r_empty;
    assign w_op      = fifo_op_t'({w_push_ok, w_pop_ok});

    assign w_ovf_set = wr & r_full & ~rd;
    assign w_unf_set = rd & r_empty;

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wptr (
        .clk    (clk),
        .reset  (reset),
        .i_inc  (w_push_ok),
        .o_ptr  (w_wptr),
        .o_succ (w_wptr_succ)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rptr (
        .clk    (clk),
        .reset  (reset),
        .i_inc  (w_pop_ok),
        .o_ptr  (w_rptr),
        .o_succ (w_rptr_succ)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves it unassigned (no latch inference).
    always_comb begin
        w_count_nxt = r_count;
        w_full_nxt  = r_full;
        w_empty_nxt = r_empty;
        case (w_op)
            NOP:      ;
            PUSH: begin
                w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
                w_empty_nxt = 1'b0;
                w_full_nxt  = (w_wptr_succ == w_rptr);
            end
            POP: begin
                w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
                w_full_nxt  = 1'b0;
                w_empty_nxt = (w_rptr_succ == w_wptr);
            end
            PUSH_POP: ;
        endcase
    end

    // NOTE: only control state is reset; the storage array needs no clear
    // because empty/count already mark every entry as invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_empty     <= w_empty_nxt;
            // Set has priority over a coincident clear.
            r_overflow  <= w_ovf_set | (r_overflow & ~clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~clr_err);
        end
    end

`ifdef FIFO_CTRL_THRESH_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic r_almost_full;
    logic r_almost_empty;

    // Computed from next-count so the thresholds move on the same edge as count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= AF_CNT);
            r_almost_empty <= (w_count_nxt <= AE_CNT);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`else
    assign almost_full  = r_full;
    assign almost_empty = r_empty;
`endif

    assign wr_en     = w_push_ok;
    assign w_addr    = w_wptr;
    assign r_addr    = w_rptr;
    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: driver pushes expected snapshots from an
// occupancy/arithmetic reference model; a negedge monitor pops and compares.
module tb_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          clr_err = 1'b0;
    logic          wr_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .wr_en        (wr_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wr_en;
        int w_addr;
        int r_addr;
        int count;
        int full;
        int empty;
        int af;
        int ae;
        int ovf;
        int unf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: total pushes/pops modulo depth give the addresses,
    // their difference gives occupancy.
    int   n_push = 0;
    int   n_pop  = 0;
    int   m_ovf  = 0;
    int   m_unf  = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge; the monitor samples at
    // the falling edge, seeing registered state from the last edge and wr_en
    // for the inputs currently applied.
    task automatic step(input bit i_wr, input bit i_rd, input bit i_clr, input bit i_rst);
        exp_t e;
        int   occ;
        bit   push_ok;
        bit   pop_ok;
        @(posedge clk);
        #2;
        wr      = i_wr;
        rd      = i_rd;
        clr_err = i_clr;
        reset   = i_rst;
        if (i_rst) begin
            n_push = 0;
            n_pop  = 0;
            m_ovf  = 0;
            m_unf  = 0;
        end
        occ     = n_push - n_pop;
        push_ok = !i_rst && i_wr && (occ < DEPTH || i_rd);
        pop_ok  = !i_rst && i_rd && occ > 0;
        e.wr_en  = i_rst ? int'(i_wr) : int'(push_ok);
        e.w_addr = n_push % DEPTH;
        e.r_addr = n_pop % DEPTH;
        e.count  = occ;
        e.full   = int'(occ == DEPTH);
        e.empty  = int'(occ == 0);
`ifdef FIFO_CTRL_THRESH_EN
        e.af     = int'(occ >= AF);
        e.ae     = int'(occ <= AE);
`else
        e.af     = e.full;
        e.ae     = e.empty;
`endif
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        sb.push_back(e);
        if (!i_rst) begin
            m_ovf  = int'((i_wr && occ == DEPTH && !i_rd) || (m_ovf != 0 && !i_clr));
            m_unf  = int'((i_rd && occ == 0) || (m_unf != 0 && !i_clr));
            n_push = n_push + int'(push_ok);
            n_pop  = n_pop + int'(pop_ok);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("wr_en",        int'(wr_en),        e.wr_en);
            check("w_addr",       int'(w_addr),       e.w_addr);
            check("r_addr",       int'(r_addr),       e.r_addr);
            check("count",        int'(count),        e.count);
            check("full",         int'(full),         e.full);
            check("empty",        int'(empty),        e.empty);
            check("almost_full",  int'(almost_full),  e.af);
            check("almost_empty", int'(almost_empty), e.ae);
            check("overflow",     int'(overflow),     e.ovf);
            check("underflow",    int'(underflow),    e.unf);
        end
    end

    initial begin
        // Reset, then idle.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);

        // Fill, overflow attempt, clear.
        repeat (4) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Simultaneous push/pop while full.
        repeat (3) step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        // Overflow coincident with clear: set wins.
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);

        // Drain, underflow, then push/pop on empty.
        repeat (4) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);

        // Wrap: interleaved pushes and pops across the 3->0 boundary.
        repeat (6) begin
            step(1, 0, 0, 0);
            step(0, 1, 0, 0);
        end
        step(0, 0, 0, 0);

        // Threshold walk up and down.
        repeat (4) step(1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);

        // Randomized phases with fill/drain bias and an occasional reset.
        for (int ph = 0; ph < 12; ph++) begin
            int wbias;
            int rbias;
            wbias = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            rbias = 100 - wbias;
            for (int c = 0; c < 40; c++) begin
                bit rw;
                bit rr;
                bit rc;
                rw = ($urandom_range(99) < wbias);
                rr = ($urandom_range(99) < rbias);
                rc = ($urandom_range(99) < 10);
                step(rw, rr, rc, 0);
            end
            if (ph == 5) step(1, 0, 0, 1);
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
